sram_ctrl: RTL

Single-outstanding request controller that drives one `sram` macro instance from a valid/ready request/response bus. It issues the macro's active-low CEN/GWEN/WEN controls and captures Q one cycle after each read. Because the macro writes `~WEN & D` and so clears masked bits, byte-strobed writes are performed as read-modify-write. The block sits between core-side load/store or fetch logic and the on-chip SRAM.

---
 rtl/sram_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/sram_ctrl.sv
// Single-outstanding valid/ready controller for one SRAM macro. Byte-strobed writes are done as read-modify-write.
// Latency: full/zero-strobe write ack on the accept edge; read and partial write respond one edge later. SRAM_CTRL_CLEAR_EN adds a zero-fill sweep after reset.
module sram_ctrl #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 512,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WIDTH-1:0]  req_wdata,
  input  logic [WIDTH/8-1:0] req_strb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [WIDTH-1:0]  rsp_rdata,
  output logic              sram_cen,
  output logic              sram_gwen,
  output logic [WIDTH-1:0]  sram_wen,
  output logic [ADDR_W-1:0] sram_a,
  output logic [WIDTH-1:0]  sram_d,
  input  logic [WIDTH-1:0]  sram_q
);

  localparam int NB = WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_WAIT  = 2'd1,
    RMW_WAIT = 2'd2
`ifdef SRAM_CTRL_CLEAR_EN
    , CLEAR  = 2'd3
`endif
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  wdata;
    logic [NB-1:0]     strb;
  } rmw_t;

  state_t             state_q, state_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_write_q, rsp_write_d;
  logic [WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  rmw_t               rmw_q, rmw_d;
`ifdef SRAM_CTRL_CLEAR_EN
  logic [ADDR_W-1:0]  clr_addr_q, clr_addr_d;
`endif

  logic accept;
  logic strb_full;
  logic strb_none;

  assign req_ready = (state_q == IDLE) && (!rsp_valid_q || rsp_ready);
  assign accept    = req_valid && req_ready;
  assign strb_full = &req_strb;
  assign strb_none = ~|req_strb;

  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;
  // The macro writes ~WEN & D, so bit masking is never used; partial writes go through RMW.
  assign sram_wen  = '0;

  always_comb begin
    state_d     = state_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rmw_d       = rmw_q;
`ifdef SRAM_CTRL_CLEAR_EN
    clr_addr_d  = clr_addr_q;
`endif
    sram_cen    = 1'b1;
    sram_gwen   = 1'b1;
    sram_a      = '0;
    sram_d      = '0;

    if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
      rsp_write_d = 1'b0;
      rsp_rdata_d = '0;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!req_write) begin
            sram_cen = 1'b0;
            sram_a   = req_addr;
            state_d  = RD_WAIT;
          end else if (strb_none) begin
            rsp_valid_d = 1'b1;
            rsp_write_d = 1'b1;
            rsp_rdata_d = '0;
          end else if (strb_full) begin
            sram_cen    = 1'b0;
            sram_gwen   = 1'b0;
            sram_a      = req_addr;
            sram_d      = req_wdata;
            rsp_valid_d = 1'b1;
            rsp_write_d = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            // Fetch the old word now; the merged write is issued next cycle.
            sram_cen    = 1'b0;
            sram_a      = req_addr;
            rmw_d.addr  = req_addr;
            rmw_d.wdata = req_wdata;
            rmw_d.strb  = req_strb;
            state_d     = RMW_WAIT;
          end
        end
      end

      RD_WAIT: begin
        rsp_valid_d = 1'b1;
        rsp_write_d = 1'b0;
        rsp_rdata_d = sram_q;
        state_d     = IDLE;
      end

      RMW_WAIT: begin
        sram_cen  = 1'b0;
        sram_gwen = 1'b0;
        sram_a    = rmw_q.addr;
        for (int b = 0; b < NB; b++) begin
          sram_d[8*b +: 8] = rmw_q.strb[b] ? rmw_q.wdata[8*b +: 8] : sram_q[8*b +: 8];
        end
        rsp_valid_d = 1'b1;
        rsp_write_d = 1'b1;
        rsp_rdata_d = '0;
        state_d     = IDLE;
      end

`ifdef SRAM_CTRL_CLEAR_EN
      CLEAR: begin
        sram_cen   = 1'b0;
        sram_gwen  = 1'b0;
        sram_a     = clr_addr_q;
        sram_d     = '0;
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == ADDR_W'(DEPTH - 1)) begin
          state_d = IDLE;
        end
      end
`endif

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
`ifdef SRAM_CTRL_CLEAR_EN
      state_q    <= CLEAR;
      clr_addr_q <= '0;
`else
      state_q    <= IDLE;
`endif
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rmw_q       <= '0;
    end else begin
      state_q     <= state_d;
`ifdef SRAM_CTRL_CLEAR_EN
      clr_addr_q  <= clr_addr_d;
`endif
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rmw_q       <= rmw_d;
    end
  end

endmodule
